// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared bus command types, widths and memory tag owner encoding
package mem_bus_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int NUM_MEM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } MEM_OWNER;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// rtl/mem_bus_arbiter_tag_table.sv - mem_tag_table: per-tag valid/owner tracking for outstanding loads
import mem_bus_arbiter_pkg::*;

module mem_tag_table #(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  logic [3:0] alloc_tag,
  input  MEM_OWNER   alloc_owner,
  input  logic [3:0] complete_tag,
  output logic       complete_hit,
  output MEM_OWNER   complete_owner,
  output logic       tag_error
);

  localparam logic [3:0] MAX_TAG = 4'(NUM_TAGS);

  logic [15:0] valid;
  MEM_OWNER    owner [16];

  logic alloc_in_range;
  logic complete_in_range;
  logic alloc_ok;
  logic same_tag_recycle;
  logic error_set;

  always_comb begin
    alloc_in_range    = (alloc_tag != 4'd0) && (alloc_tag <= MAX_TAG);
    complete_in_range = (complete_tag != 4'd0) && (complete_tag <= MAX_TAG);
    alloc_ok          = alloc_en && alloc_in_range;
    complete_hit      = complete_in_range && valid[complete_tag];
    complete_owner    = owner[complete_tag];
    // A tag retiring and being handed out again in the same cycle is legal reuse.
    same_tag_recycle  = complete_hit && (complete_tag == alloc_tag);
    error_set = ((complete_tag != 4'd0) && !complete_hit)
              || (alloc_en && !alloc_in_range)
              || (alloc_ok && valid[alloc_tag] && !same_tag_recycle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid     <= '0;
      tag_error <= 1'b0;
    end else begin
      if (complete_hit) begin
        valid[complete_tag] <= 1'b0;
      end
      // Allocation follows the clear so a same-cycle reissue keeps the entry.
      if (alloc_ok) begin
        valid[alloc_tag] <= 1'b1;
        owner[alloc_tag] <= alloc_owner;
      end
      tag_error <= tag_error | error_set;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - ICache/DCache memory bus arbiter with I-side starvation guard and tag routing
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
  parameter int I_STARVE_LIMIT = 4,
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic            clock,
  input  logic            reset,
  input  BUS_COMMAND      Ictrl2arb_command,
  input  logic [XLEN-1:0] Ictrl2arb_addr,
  input  BUS_COMMAND      Dctrl2arb_command,
  input  logic [XLEN-1:0] Dctrl2arb_addr,
  input  logic [63:0]     Dctrl2arb_data,
  input  logic [3:0]      mem2arb_response,
  input  logic [3:0]      mem2arb_tag,
  input  logic [63:0]     mem2arb_data,
  output BUS_COMMAND      arb2mem_command,
  output logic [XLEN-1:0] arb2mem_addr,
  output logic [63:0]     arb2mem_data,
  output logic            reject_I_req,
  output logic            reject_D_req,
  output logic [3:0]      arb2Ictrl_response,
  output logic [3:0]      arb2Dctrl_response,
  output logic [3:0]      arb2Ictrl_tag,
  output logic [3:0]      arb2Dctrl_tag,
  output logic [63:0]     arb2ctrl_data,
  output logic            arb_tag_error
);

  localparam int CNT_W = $clog2(I_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(I_STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             i_req;
  logic             d_req;
  logic             grant_i;
  logic             grant_d;
  logic             alloc_en;
  MEM_OWNER         alloc_owner;
  logic             complete_hit;
  MEM_OWNER         complete_owner;

  always_comb begin
    i_req   = (Ictrl2arb_command != BUS_NONE);
    d_req   = (Dctrl2arb_command != BUS_NONE);
    grant_i = i_req && (!d_req || (starve_cnt >= STARVE_MAX));
    grant_d = d_req && !grant_i;

    arb2mem_command = BUS_NONE;
    arb2mem_addr    = '0;
    if (grant_i) begin
      arb2mem_command = Ictrl2arb_command;
      arb2mem_addr    = Ictrl2arb_addr;
    end else if (grant_d) begin
      arb2mem_command = Dctrl2arb_command;
      arb2mem_addr    = Dctrl2arb_addr;
    end
    arb2mem_data  = Dctrl2arb_data;
    arb2ctrl_data = mem2arb_data;

    // A granted-but-refused side sees response 0, never a reject.
    reject_I_req       = i_req && !grant_i;
    reject_D_req       = d_req && !grant_d;
    arb2Ictrl_response = grant_i ? mem2arb_response : 4'd0;
    arb2Dctrl_response = grant_d ? mem2arb_response : 4'd0;

    alloc_en    = (arb2mem_command == BUS_LOAD) && (mem2arb_response != 4'd0);
    alloc_owner = grant_i ? OWNER_I : OWNER_D;

    arb2Ictrl_tag = (complete_hit && complete_owner == OWNER_I) ? mem2arb_tag : 4'd0;
    arb2Dctrl_tag = (complete_hit && complete_owner == OWNER_D) ? mem2arb_tag : 4'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  mem_tag_table #(
    .NUM_TAGS(NUM_TAGS)
  ) u_tag_table (
    .clock          (clock),
    .reset          (reset),
    .alloc_en       (alloc_en),
    .alloc_tag      (mem2arb_response),
    .alloc_owner    (alloc_owner),
    .complete_tag   (mem2arb_tag),
    .complete_hit   (complete_hit),
    .complete_owner (complete_owner),
    .tag_error      (arb_tag_error)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed scoreboard bench for mem_bus_arbiter
import mem_bus_arbiter_pkg::*;

module tb_mem_bus_arbiter;

  logic            clock;
  logic            reset;
  BUS_COMMAND      i_cmd;
  logic [XLEN-1:0] i_addr;
  BUS_COMMAND      d_cmd;
  logic [XLEN-1:0] d_addr;
  logic [63:0]     d_data;
  logic [3:0]      m_resp;
  logic [3:0]      m_tag;
  logic [63:0]     m_data;
  BUS_COMMAND      o_cmd;
  logic [XLEN-1:0] o_addr;
  logic [63:0]     o_data;
  logic            rej_i;
  logic            rej_d;
  logic [3:0]      resp_i;
  logic [3:0]      resp_d;
  logic [3:0]      tag_i;
  logic [3:0]      tag_d;
  logic [63:0]     c_data;
  logic            tag_err;

  mem_bus_arbiter #(.I_STARVE_LIMIT(4), .NUM_TAGS(15)) dut (
    .clock              (clock),
    .reset              (reset),
    .Ictrl2arb_command  (i_cmd),
    .Ictrl2arb_addr     (i_addr),
    .Dctrl2arb_command  (d_cmd),
    .Dctrl2arb_addr     (d_addr),
    .Dctrl2arb_data     (d_data),
    .mem2arb_response   (m_resp),
    .mem2arb_tag        (m_tag),
    .mem2arb_data       (m_data),
    .arb2mem_command    (o_cmd),
    .arb2mem_addr       (o_addr),
    .arb2mem_data       (o_data),
    .reject_I_req       (rej_i),
    .reject_D_req       (rej_d),
    .arb2Ictrl_response (resp_i),
    .arb2Dctrl_response (resp_d),
    .arb2Ictrl_tag      (tag_i),
    .arb2Dctrl_tag      (tag_d),
    .arb2ctrl_data      (c_data),
    .arb_tag_error      (tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum {S_CMD, S_ADDR, S_WDATA, S_RDATA, S_REJ_I, S_REJ_D, S_RESP_I, S_RESP_D,
                S_TAG_I, S_TAG_D, S_ERR, S_CNT, S_VALID, S_OWNER} sig_e;

  typedef struct {
    sig_e        sig;
    int          idx;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   passed;
  int   failed;

  function automatic logic [63:0] observe(sig_e s, int idx);
    case (s)
      S_CMD:    return 64'(o_cmd);
      S_ADDR:   return 64'(o_addr);
      S_WDATA:  return o_data;
      S_RDATA:  return c_data;
      S_REJ_I:  return 64'(rej_i);
      S_REJ_D:  return 64'(rej_d);
      S_RESP_I: return 64'(resp_i);
      S_RESP_D: return 64'(resp_d);
      S_TAG_I:  return 64'(tag_i);
      S_TAG_D:  return 64'(tag_d);
      S_ERR:    return 64'(tag_err);
      S_CNT:    return 64'(dut.starve_cnt);
      S_VALID:  return 64'(dut.u_tag_table.valid[idx]);
      S_OWNER:  return 64'(dut.u_tag_table.owner[idx]);
      default:  return 64'hdead;
    endcase
  endfunction

  task automatic push(sig_e s, logic [63:0] e, int idx = 0);
    exp_t x;
    x.sig = s;
    x.idx = idx;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drive(BUS_COMMAND ic, logic [XLEN-1:0] ia, BUS_COMMAND dc,
                       logic [XLEN-1:0] da, logic [3:0] resp, logic [3:0] tag);
    i_cmd  = ic;
    i_addr = ia;
    d_cmd  = dc;
    d_addr = da;
    m_resp = resp;
    m_tag  = tag;
  endtask

  task automatic idle();
    drive(BUS_NONE, '0, BUS_NONE, '0, 4'd0, 4'd0);
  endtask

  // Compare everything queued for this cycle mid-cycle, then advance past the edge.
  task automatic step();
    exp_t        x;
    logic [63:0] o;
    @(negedge clock);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.sig, x.idx);
      total++;
      assert (o === x.exp) passed++;
      else begin
        failed++;
        $error("FAIL %s[%0d] observed=%0h expected=%0h", x.sig.name(), x.idx, o, x.exp);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int       mcnt;
  logic     mgi;
  MEM_OWNER mown [16];

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    d_data = 64'h1122_3344_5566_7788;
    m_data = 64'hcafe_f00d_0bad_beef;
    do_reset();

    // Reset state with idle inputs
    push(S_CMD, 64'(BUS_NONE));
    push(S_REJ_I, 0); push(S_REJ_D, 0);
    push(S_RESP_I, 0); push(S_RESP_D, 0);
    push(S_TAG_I, 0); push(S_TAG_D, 0);
    push(S_ERR, 0); push(S_CNT, 0);
    push(S_WDATA, 64'h1122_3344_5566_7788);
    push(S_RDATA, 64'hcafe_f00d_0bad_beef);
    step();

    // I-only load, accepted as tag 3, completes two cycles later
    drive(BUS_LOAD, 32'h100, BUS_NONE, '0, 4'd3, 4'd0);
    push(S_CMD, 64'(BUS_LOAD)); push(S_ADDR, 64'h100);
    push(S_RESP_I, 3); push(S_RESP_D, 0); push(S_REJ_I, 0);
    step();
    idle();
    push(S_VALID, 1, 3); push(S_OWNER, 64'(OWNER_I), 3);
    step();
    drive(BUS_NONE, '0, BUS_NONE, '0, 4'd0, 4'd3);
    push(S_TAG_I, 3); push(S_TAG_D, 0);
    step();
    idle();
    push(S_VALID, 0, 3); push(S_ERR, 0);
    step();

    // Both request every cycle; I forced through once the counter reaches the limit
    mcnt = 0;
    for (int k = 0; k < 5; k++) begin
      drive(BUS_LOAD, 32'h100, BUS_LOAD, 32'h200 + 32'(8 * k), 4'(k + 1), 4'd0);
      mgi = (mcnt >= 4);
      mown[k + 1] = mgi ? OWNER_I : OWNER_D;
      push(S_CNT, 64'(mcnt));
      push(S_REJ_I, 64'(!mgi)); push(S_REJ_D, 64'(mgi));
      push(S_ADDR, mgi ? 64'h100 : 64'(32'h200 + 32'(8 * k)));
      push(S_RESP_I, mgi ? 64'(k + 1) : 0);
      push(S_RESP_D, mgi ? 0 : 64'(k + 1));
      mcnt = mgi ? 0 : ((mcnt < 4) ? mcnt + 1 : 4);
      step();
    end
    idle();
    push(S_CNT, 64'(mcnt));
    for (int t = 1; t <= 5; t++) begin
      push(S_VALID, 1, t); push(S_OWNER, 64'(mown[t]), t);
    end
    step();
    for (int t = 1; t <= 5; t++) begin
      drive(BUS_NONE, '0, BUS_NONE, '0, 4'd0, 4'(t));
      push(S_TAG_I, (mown[t] == OWNER_I) ? 64'(t) : 0);
      push(S_TAG_D, (mown[t] == OWNER_D) ? 64'(t) : 0);
      step();
    end
    idle();
    push(S_ERR, 0);
    step();

    // Store accepted as tag 5 allocates nothing; its completion is an error
    drive(BUS_NONE, '0, BUS_STORE, 32'h300, 4'd5, 4'd0);
    push(S_CMD, 64'(BUS_STORE)); push(S_RESP_D, 5); push(S_REJ_D, 0);
    step();
    idle();
    push(S_VALID, 0, 5);
    step();
    drive(BUS_NONE, '0, BUS_NONE, '0, 4'd0, 4'd5);
    push(S_TAG_I, 0); push(S_TAG_D, 0); push(S_ERR, 0);
    step();
    idle();
    push(S_ERR, 1);
    step();
    do_reset();
    push(S_ERR, 0);
    step();

    // Refused I load never advances the counter nor rejects
    for (int k = 0; k < 6; k++) begin
      drive(BUS_LOAD, 32'h108, BUS_NONE, '0, 4'd0, 4'd0);
      push(S_REJ_I, 0); push(S_RESP_I, 0); push(S_CNT, 0);
      step();
    end
    idle();
    push(S_CNT, 0); push(S_VALID, 0, 1);
    step();

    // Tag 7 retires to D while being re-issued to I in the same cycle
    drive(BUS_NONE, '0, BUS_LOAD, 32'h400, 4'd7, 4'd0);
    push(S_RESP_D, 7);
    step();
    drive(BUS_LOAD, 32'h110, BUS_NONE, '0, 4'd7, 4'd7);
    push(S_TAG_D, 7); push(S_TAG_I, 0); push(S_RESP_I, 7);
    step();
    idle();
    push(S_VALID, 1, 7); push(S_OWNER, 64'(OWNER_I), 7); push(S_ERR, 0);
    step();
    drive(BUS_NONE, '0, BUS_NONE, '0, 4'd0, 4'd7);
    push(S_TAG_I, 7); push(S_TAG_D, 0);
    step();
    idle();
    push(S_ERR, 0);
    step();

    // Reset with tags 2 and 9 outstanding forgets them
    drive(BUS_NONE, '0, BUS_LOAD, 32'h500, 4'd9, 4'd0);
    step();
    drive(BUS_LOAD, 32'h118, BUS_NONE, '0, 4'd2, 4'd0);
    step();
    idle();
    push(S_VALID, 1, 2); push(S_VALID, 1, 9);
    step();
    do_reset();
    push(S_VALID, 0, 2); push(S_VALID, 0, 9); push(S_ERR, 0);
    step();
    drive(BUS_NONE, '0, BUS_NONE, '0, 4'd0, 4'd2);
    push(S_TAG_I, 0); push(S_TAG_D, 0);
    step();
    idle();
    push(S_ERR, 1);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single memory bus between the ICache controller and the DCache controller. DCache requests normally win. A starvation counter guarantees that fetch eventually gets a grant. The arbiter records which requester owns each accepted memory transaction tag, so the completion tag and data are returned only to the requester that issued the load. It sits between both cache controllers and the memory interface and produces the `reject_I_req` that the ICache controller consumes.

## Interface
Parameters:
- `I_STARVE_LIMIT`, default 4: consecutive I-side arbitration losses before I is forced ahead of D.
- `NUM_TAGS`, default 15: usable memory tags, numbered 1..15; tag 0 means "none".

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `Ictrl2arb_command` in BUS_COMMAND: ICache request, either BUS_NONE or BUS_LOAD.
- `Ictrl2arb_addr` in XLEN: ICache address, 8-byte aligned.
- `Dctrl2arb_command` in BUS_COMMAND: DCache request, one of BUS_NONE, BUS_LOAD or BUS_STORE.
- `Dctrl2arb_addr` in XLEN: DCache address.
- `Dctrl2arb_data` in 64: DCache store data.
- `mem2arb_response` in 4: memory accept tag for the current command; 0 means refused.
- `mem2arb_tag` in 4: completion tag of returning load data; 0 means none.
- `mem2arb_data` in 64: returning load data.
- `arb2mem_command` out BUS_COMMAND: granted command, or BUS_NONE.
- `arb2mem_addr` out XLEN: granted address.
- `arb2mem_data` out 64: store data, always taken from D.
- `reject_I_req` out 1: I requested this cycle and was not granted.
- `reject_D_req` out 1: D requested this cycle and was not granted.
- `arb2Ictrl_response` out 4 and `arb2Dctrl_response` out 4: `mem2arb_response` if that side is granted, else 0.
- `arb2Ictrl_tag` out 4 and `arb2Dctrl_tag` out 4: `mem2arb_tag` if the table owner is that side, else 0.
- `arb2ctrl_data` out 64: `mem2arb_data`, broadcast to both sides.
- `arb_tag_error` out 1: sticky flag; a completion arrived for an invalid tag, or an accept reused a valid tag.

## Operation
Arbitration (combinational, same cycle as the request):
- A request from a side means its command is not BUS_NONE.
- If only one side requests, that side is granted.
- If both request, D is granted, unless `starve_cnt` >= `I_STARVE_LIMIT`, in which case I is granted.
- The granted side's command and address drive `arb2mem_*`. With no request, `arb2mem_command` = BUS_NONE.

Starvation counter (`starve_cnt`, clog2(I_STARVE_LIMIT+1) bits):
- Cleared when I is granted or I is not requesting.
- Incremented when I requests and loses.
- Saturates at `I_STARVE_LIMIT`.
- A memory refusal (response 0) of a granted I request does not increment the counter.

Tag table (`NUM_TAGS` entries, each `valid` + `owner`):
- Issue: a granted BUS_LOAD with `mem2arb_response` != 0 sets `valid[resp]` and `owner[resp]` to the granted side at the next edge.
- Stores never allocate an entry.
- Completion: when `mem2arb_tag` != 0 and `valid[tag]` is set, the tag is routed to the owner and the entry is cleared at the next edge.
- A completion on an invalid tag is routed to neither side and sets `arb_tag_error`.
- If the same tag completes and is re-issued in one cycle, the new allocation wins. That case is not an error.

## Timing
- Grant, `reject_*`, `arb2mem_*` and the routed response are combinational from the request and memory inputs, with zero-cycle latency.
- Table and counter update at posedge. A completion tag is valid for routing no earlier than the cycle after its issue.
- Reset values:
  - Table all invalid; `starve_cnt` = 0; `arb_tag_error` = 0.
  - Outputs then follow the combinational rules: with idle inputs, `arb2mem_command` = BUS_NONE and all responses, tags and rejects are 0.
- Reset mid-operation: all in-flight tags are forgotten, and later completions for them raise `arb_tag_error`. Controllers are reset together, so this is benign.
- A side whose grant is refused must retry. Its rejection is signalled only through response = 0, not through `reject_*`.

## Structure
- BUS_COMMAND and XLEN come from the shared include package.
- Add `MEM_OWNER` enum {OWNER_I, OWNER_D} and `NUM_MEM_TAGS` = 15 to the shared package.
- One sub-module, `mem_tag_table`: valid/owner arrays, allocate port, complete port, owner lookup and error output.
- Arbitration and the starvation counter stay in the top module.

## Test plan
- I only, load at 0x100, memory response 3; completion tag 3 two cycles later -> `arb2Ictrl_response` = 3 and `reject_I_req` = 0; `arb2Ictrl_tag` = 3, `arb2Dctrl_tag` = 0; entry 3 cleared.
- Both request every cycle, limit 4, every request accepted -> D granted for 4 cycles with `reject_I_req` = 1; I granted on cycle 5 with `reject_D_req` = 1; counter back to 0.
- D BUS_STORE, response 5; inject `mem2arb_tag` = 5 -> no entry allocated; tag routed to neither side; `arb_tag_error` = 1.
- I load refused (response 0) for 6 cycles while D is idle -> `starve_cnt` stays 0 and `reject_I_req` stays 0.
- Tag 7 owned by D completes while I is granted with response 7 in the same cycle -> `arb2Dctrl_tag` = 7; entry 7 becomes owner I, valid; no error.
- Reset asserted with tags 2 and 9 outstanding -> table cleared; later completion on tag 2 routed nowhere and `arb_tag_error` = 1.
